// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB has priority, long-latency results are buffered
// in a small FIFO, and a starvation counter forces periodic WB stall slots to drain it.
module rf_wport_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_w_en,
    input  logic [4:0]  wb_w_addr,
    input  logic [31:0] wb_w_data,
    input  logic        ll_valid,
    input  logic [4:0]  ll_addr,
    input  logic [31:0] ll_data,
    output logic        ll_ready,
    output logic        wb_stall,
    output logic        rf_w_en,
    output logic [4:0]  rf_w_addr,
    output logic [31:0] rf_w_data,
    output logic        rf_w_src,
    output logic [31:0] ll_pending,
    output logic        proto_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    logic [4:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;

    logic          empty, full;
    logic          drain, wb_win, wt;
    logic          push, pop;
    logic [4:0]    sel_addr;
    logic [31:0]   sel_data;
    logic          sel_src;
    logic          wr_ok;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign ll_ready = ~full;

    always_comb begin
        drain  = 1'b0;
        wb_win = 1'b0;
        wt     = 1'b0;
        if (wb_stall && !empty)
            drain = 1'b1;
        else if (wb_w_en)
            wb_win = 1'b1;
        else if (!empty)
            drain = 1'b1;
        else if (ll_valid)
            wt = 1'b1;
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_src  = 1'b0;
        if (drain) begin
            sel_addr = mem_addr[rd_ptr];
            sel_data = mem_data[rd_ptr];
            sel_src  = 1'b1;
        end else if (wb_win) begin
            sel_addr = wb_w_addr;
            sel_data = wb_w_data;
        end else if (wt) begin
            sel_addr = ll_addr;
            sel_data = ll_data;
            sel_src  = 1'b1;
        end
    end

    // GR[0] writes are consumed but never reach the register file
    assign wr_ok     = reset & (drain | wb_win | wt) & (sel_addr != 5'd0);
    assign rf_w_en   = wr_ok;
    assign rf_w_addr = sel_addr;
    assign rf_w_data = wr_ok ? sel_data : 32'd0;
    assign rf_w_src  = sel_src;

    // full uses registered occupancy only, so a same-cycle pop never admits a push
    assign push = ll_valid & ~full & ~wt & (ll_addr != 5'd0);
    assign pop  = drain;

    always_comb begin
        ll_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i[CW-1:0] < count)
                ll_pending[mem_addr[rd_ptr + i[PW-1:0]]] = 1'b1;
        end
        ll_pending[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= ll_addr;
            mem_data[wr_ptr] <= ll_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (wb_stall && wb_w_en)
                proto_err <= 1'b1;

            wb_stall <= 1'b0;
            if (empty || drain || wt) begin
                starve_cnt <= '0;
            end else if (wb_win) begin
                if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
                    starve_cnt <= '0;
                    wb_stall   <= 1'b1;
                end else begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
        end
    end

endmodule
